pic_prog_loader: RTL

Serial bootloader that fills the PIC16C57 core's 2048x12 program memory from a byte stream, typically the UART receiver. It drives the program memory write port and holds the CPU in reset while an image is loaded. It sits directly upstream of the CPU instruction fetch path and replaces the simulation-only memory initialisation.

---
 rtl/pic_prog_loader_if.sv | 28 ++
 rtl/pic_prog_loader.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pic_prog_loader_if.sv
// Byte-stream input and program-memory write port of the PIC16C57 bootloader.
// The master side is the loader; the slave side is the UART/memory/CPU glue.
interface pic_prog_loader_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int INST_WIDTH = 12
);
    logic [7:0]            rxData;
    logic                  rxValid;
    logic                  rxReady;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [INST_WIDTH-1:0] memData;
    logic                  cpuHold;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [1:0]            errCode;

    modport master (
        input  rxData, rxValid,
        output rxReady, memWe, memAddr, memData, cpuHold, busy, done, err, errCode
    );

    modport slave (
        output rxData, rxValid,
        input  rxReady, memWe, memAddr, memData, cpuHold, busy, done, err, errCode
    );
endinterface

// File: rtl/pic_prog_loader.sv
// Serial bootloader: parses SYNC/address/count/data/checksum frames and writes
// 12-bit words into program memory while holding the CPU in reset.
module pic_prog_loader #(
    parameter int         ADDR_WIDTH     = 11,
    parameter int         INST_WIDTH     = 12,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input logic                clk,
    input logic                rst,
    pic_prog_loader_if.master  bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA_HI, DATA_LO, WRITE, CSUM
    } state_t;

    localparam int               TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [11:0]      MAX_WORDS = 12'(1 << ADDR_WIDTH);

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [11:0]             cnt_reg;
    logic [11:0]             wordCnt_reg;
    logic [INST_WIDTH-9:0]   dataHi_reg;
    logic [7:0]              csum_reg;
    logic [TW-1:0]           tmo_reg;
    logic                    memWe_reg;
    logic [ADDR_WIDTH-1:0]   memAddr_reg;
    logic [INST_WIDTH-1:0]   memData_reg;
    logic                    cpuHold_reg;
    logic                    done_reg;
    logic                    err_reg;
    logic [1:0]              errCode_reg;

    logic        accept;
    logic [7:0]  csumNext;
    logic [11:0] cntNew;
    logic [11:0] wordCntNext;

    assign accept      = bus.rxValid && bus.rxReady;
    assign csumNext    = csum_reg + bus.rxData;
    assign cntNew      = {cnt_reg[11:8], bus.rxData};
    assign wordCntNext = wordCnt_reg + 12'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            cnt_reg     <= '0;
            wordCnt_reg <= '0;
            dataHi_reg  <= '0;
            csum_reg    <= '0;
            tmo_reg     <= '0;
            memWe_reg   <= 1'b0;
            memAddr_reg <= '0;
            memData_reg <= '0;
            cpuHold_reg <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
            errCode_reg <= 2'b00;
        end else begin
            done_reg  <= 1'b0;
            memWe_reg <= 1'b0;

            // Saturates one short of the limit so a timeout that matures during
            // WRITE is taken on the following cycle.
            if (state_reg == IDLE || accept)
                tmo_reg <= '0;
            else if (tmo_reg != TMO_LAST)
                tmo_reg <= tmo_reg + 1'b1;

            if (state_reg == WRITE) begin
                addr_reg    <= addr_reg + 1'b1;
                wordCnt_reg <= wordCntNext;
                state_reg   <= (wordCntNext == cnt_reg) ? CSUM : DATA_HI;
            end else if (state_reg != IDLE && !accept && tmo_reg == TMO_LAST) begin
                err_reg     <= 1'b1;
                errCode_reg <= 2'b10;
                state_reg   <= IDLE;
            end else if (accept) begin
                if (state_reg != IDLE)
                    csum_reg <= csumNext;
                case (state_reg)
                    IDLE: begin
                        if (bus.rxData == SYNC_BYTE) begin
                            state_reg   <= ADDR_HI;
                            cpuHold_reg <= 1'b1;
                            err_reg     <= 1'b0;
                            errCode_reg <= 2'b00;
                            csum_reg    <= '0;
                            wordCnt_reg <= '0;
                        end
                    end
                    ADDR_HI: begin
                        addr_reg[ADDR_WIDTH-1:8] <= bus.rxData[ADDR_WIDTH-9:0];
                        state_reg <= ADDR_LO;
                    end
                    ADDR_LO: begin
                        addr_reg[7:0] <= bus.rxData;
                        state_reg     <= CNT_HI;
                    end
                    CNT_HI: begin
                        cnt_reg   <= {bus.rxData[3:0], 8'h00};
                        state_reg <= CNT_LO;
                    end
                    CNT_LO: begin
                        cnt_reg <= cntNew;
                        if (cntNew > MAX_WORDS) begin
                            err_reg     <= 1'b1;
                            errCode_reg <= 2'b11;
                            state_reg   <= IDLE;
                        end else if (cntNew == 12'd0) begin
                            state_reg <= CSUM;
                        end else begin
                            state_reg <= DATA_HI;
                        end
                    end
                    DATA_HI: begin
                        dataHi_reg <= bus.rxData[INST_WIDTH-9:0];
                        state_reg  <= DATA_LO;
                    end
                    DATA_LO: begin
                        memWe_reg   <= 1'b1;
                        memAddr_reg <= addr_reg;
                        memData_reg <= {dataHi_reg, bus.rxData};
                        state_reg   <= WRITE;
                    end
                    CSUM: begin
                        state_reg <= IDLE;
                        if (csumNext == 8'h00) begin
                            done_reg    <= 1'b1;
                            cpuHold_reg <= 1'b0;
                        end else begin
                            err_reg     <= 1'b1;
                            errCode_reg <= 2'b01;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign bus.rxReady = (state_reg != WRITE);
    assign bus.busy    = (state_reg != IDLE);
    assign bus.memWe   = memWe_reg;
    assign bus.memAddr = memAddr_reg;
    assign bus.memData = memData_reg;
    assign bus.cpuHold = cpuHold_reg;
    assign bus.done    = done_reg;
    assign bus.err     = err_reg;
    assign bus.errCode = errCode_reg;
endmodule
